// File: rtl/qsys_gpo_bank.sv
// qsys_gpo_bank
// Multi-channel general-purpose output bank on an Avalon-MM slave.
// Each of CHANNELS output words has DATA with SET/CLR/TOG write aliases,
// per-lane byte enables, a registered read path and, when the macro
// QSYS_GPO_PULSE_EN is defined, a per-channel one-shot pulse generator
// that temporarily inverts selected output bits for PLEN cycles.
//
// Ports:
//   csi_MCLK_clk         system clock
//   rsi_MRST_reset       asynchronous active-high reset
//   avs_Gpo_address      {channel, reg[2:0]}
//   avs_Gpo_read         read strobe
//   avs_Gpo_write        write strobe
//   avs_Gpo_byteenable   write byte lanes
//   avs_Gpo_writedata    write data
//   avs_Gpo_readdata     registered read data
//   avs_Gpo_waitrequest  stall
//   coe_GPO              outputs, channel c at [c*WIDTH +: WIDTH]
//
// Register map per channel:
//   0 DATA (RW), 1 SET, 2 CLR, 3 TOG (W, read back DATA),
//   4 PULSE (W, reads DATA), 5 PLEN (RW, 16 bit) -- 4/5 only with
//   QSYS_GPO_PULSE_EN; otherwise they behave like the unmapped regs 6/7.

module qsys_gpo_bank #(
    parameter int          CHANNELS   = 4,
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_VAL  = 32'h5A5A5A5A,
    parameter logic [15:0] PLEN_RESET = 16'd100
) (
    input  logic                          csi_MCLK_clk,
    input  logic                          rsi_MRST_reset,
    input  logic [$clog2(CHANNELS)+2:0]   avs_Gpo_address,
    input  logic                          avs_Gpo_read,
    input  logic                          avs_Gpo_write,
    input  logic [3:0]                    avs_Gpo_byteenable,
    input  logic [31:0]                   avs_Gpo_writedata,
    output logic [31:0]                   avs_Gpo_readdata,
    output logic                          avs_Gpo_waitrequest,
    output logic [CHANNELS*WIDTH-1:0]     coe_GPO
);

    localparam logic [2:0] REG_DATA  = 3'd0;
    localparam logic [2:0] REG_SET   = 3'd1;
    localparam logic [2:0] REG_CLR   = 3'd2;
    localparam logic [2:0] REG_TOG   = 3'd3;
`ifdef QSYS_GPO_PULSE_EN
    localparam logic [2:0] REG_PULSE = 3'd4;
    localparam logic [2:0] REG_PLEN  = 3'd5;
`endif

    typedef enum logic {
        IDLE,
        RD_WAIT
    } rdState_t;

    rdState_t          state;
    rdState_t          nextState;
    logic              readStart;
    logic              rstWait;
    logic              wrAccept;
    logic [4:0]        chanSel;
    logic [2:0]        regSel;
    logic [31:0]       laneMask32;
    logic [WIDTH-1:0]  laneMask;
    logic [WIDTH-1:0]  wdMasked;
    logic [31:0]       readValue;
    logic [WIDTH-1:0]  dataReg [CHANNELS];

`ifdef QSYS_GPO_PULSE_EN
    logic [15:0]       plenReg  [CHANNELS];
    logic [15:0]       pcntReg  [CHANNELS];
    logic [WIDTH-1:0]  pmaskReg [CHANNELS];
`endif

    // Channel numbers that do not exist simply never match any channel
    // in the per-channel loops below, so they are ignored on write and
    // read back as zero without a separate range check.
    assign chanSel    = 5'(avs_Gpo_address >> 3);
    assign regSel     = avs_Gpo_address[2:0];
    assign laneMask32 = {{8{avs_Gpo_byteenable[3]}}, {8{avs_Gpo_byteenable[2]}},
                         {8{avs_Gpo_byteenable[1]}}, {8{avs_Gpo_byteenable[0]}}};
    assign laneMask   = laneMask32[WIDTH-1:0];
    assign wdMasked   = avs_Gpo_writedata[WIDTH-1:0] & laneMask;

    // Writes are taken only once the slave has left its reset stall, so a
    // master that saw waitrequest high never gets a write applied twice.
    assign wrAccept   = avs_Gpo_write && !rstWait;

    // Holds waitrequest high through reset and releases it on the first
    // clock edge after reset deasserts.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            rstWait <= 1'b1;
        end else begin
            rstWait <= 1'b0;
        end
    end

    // Read handshake state register.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A read stalls for one cycle while the data is captured, then completes
    // in RD_WAIT. A simultaneous write takes priority and the read is dropped.
    always_comb begin
        nextState           = state;
        readStart           = 1'b0;
        avs_Gpo_waitrequest = rstWait;
        case (state)
            IDLE: begin
                if (avs_Gpo_read && !avs_Gpo_write && !rstWait) begin
                    nextState           = RD_WAIT;
                    readStart           = 1'b1;
                    avs_Gpo_waitrequest = 1'b1;
                end
            end
            RD_WAIT: begin
                nextState = IDLE;
            end
        endcase
    end

    // Read mux: selects the addressed register, zero for anything unmapped.
    always_comb begin
        readValue = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chanSel == 5'(c)) begin
                case (regSel)
                    REG_DATA, REG_SET, REG_CLR, REG_TOG: readValue = 32'(dataReg[c]);
`ifdef QSYS_GPO_PULSE_EN
                    REG_PULSE: readValue = 32'(dataReg[c]);
                    REG_PLEN:  readValue = {16'h0000, plenReg[c]};
`endif
                    default: readValue = '0;
                endcase
            end
        end
    end

    // Read data is captured on the edge that ends the stall cycle and held
    // until the next read.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            avs_Gpo_readdata <= '0;
        end else if (readStart) begin
            avs_Gpo_readdata <= readValue;
        end
    end

    // DATA update: plain write merges by byte lane, the aliases apply the
    // lane-masked write data as an OR, AND-NOT or XOR mask.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                dataReg[c] <= RESET_VAL[WIDTH-1:0];
            end
        end else if (wrAccept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chanSel == 5'(c)) begin
                    case (regSel)
                        REG_DATA: dataReg[c] <= (dataReg[c] & ~laneMask) | wdMasked;
                        REG_SET:  dataReg[c] <= dataReg[c] | wdMasked;
                        REG_CLR:  dataReg[c] <= dataReg[c] & ~wdMasked;
                        REG_TOG:  dataReg[c] <= dataReg[c] ^ wdMasked;
                        default:  dataReg[c] <= dataReg[c];
                    endcase
                end
            end
        end
    end

`ifdef QSYS_GPO_PULSE_EN
    // Pulse generator: a PULSE write ORs its mask into PMASK and (re)loads the
    // counter with PLEN; the mask drops on the edge where the counter goes
    // from 1 to 0, so the inversion lasts exactly PLEN cycles. A retrigger
    // takes priority over that final countdown step. PLEN changes only take
    // effect at the next PULSE because the counter copies PLEN at load time.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                plenReg[c]  <= PLEN_RESET;
                pcntReg[c]  <= '0;
                pmaskReg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wrAccept && chanSel == 5'(c) && regSel == REG_PULSE && plenReg[c] != 16'd0) begin
                    pmaskReg[c] <= pmaskReg[c] | wdMasked;
                    pcntReg[c]  <= plenReg[c];
                end else if (pcntReg[c] != 16'd0) begin
                    pcntReg[c] <= pcntReg[c] - 16'd1;
                    if (pcntReg[c] == 16'd1) begin
                        pmaskReg[c] <= '0;
                    end
                end
                if (wrAccept && chanSel == 5'(c) && regSel == REG_PLEN) begin
                    if (avs_Gpo_byteenable[0]) begin
                        plenReg[c][7:0] <= avs_Gpo_writedata[7:0];
                    end
                    if (avs_Gpo_byteenable[1]) begin
                        plenReg[c][15:8] <= avs_Gpo_writedata[15:8];
                    end
                end
            end
        end
    end
`endif

    // Outputs are driven purely from registered state.
    always_comb begin
        coe_GPO = '0;
        for (int c = 0; c < CHANNELS; c++) begin
`ifdef QSYS_GPO_PULSE_EN
            coe_GPO[c*WIDTH +: WIDTH] = dataReg[c] ^ pmaskReg[c];
`else
            coe_GPO[c*WIDTH +: WIDTH] = dataReg[c];
`endif
        end
    end

endmodule

// File: tb/tb_qsys_gpo_bank.sv
// Testbench for qsys_gpo_bank (CHANNELS=4, WIDTH=32). Pulse scenarios are
// compiled in only when QSYS_GPO_PULSE_EN is defined, matching the DUT build.

module tb_qsys_gpo_bank;

    localparam logic [127:0] RST_PATTERN = {4{32'h5A5A5A5A}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [4:0]   addr = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [3:0]   be = '0;
    logic [31:0]  wd = '0;
    logic [31:0]  readdata;
    logic         waitreq;
    logic [127:0] coe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mData  [4];
    logic [15:0] mPlen  [4];
    logic [31:0] mPmask [4];
    int          mPend  [4];

    qsys_gpo_bank #(
        .CHANNELS(4),
        .WIDTH(32),
        .RESET_VAL(32'h5A5A5A5A),
        .PLEN_RESET(16'd100)
    ) dut (
        .csi_MCLK_clk(clk),
        .rsi_MRST_reset(reset),
        .avs_Gpo_address(addr),
        .avs_Gpo_read(read),
        .avs_Gpo_write(write),
        .avs_Gpo_byteenable(be),
        .avs_Gpo_writedata(wd),
        .avs_Gpo_readdata(readdata),
        .avs_Gpo_waitrequest(waitreq),
        .coe_GPO(coe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] laneMask(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 4; c++) begin
            mData[c]  = 32'h5A5A5A5A;
            mPlen[c]  = 16'd100;
            mPmask[c] = '0;
            mPend[c]  = 0;
        end
    endtask

    // Called just after the edge on which the write was accepted.
    task automatic modelWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        int          c;
        logic [31:0] m;
        logic [31:0] w;
        c = int'(a[4:3]);
        m = laneMask(b);
        w = d & m;
        case (a[2:0])
            3'd0: mData[c] = (mData[c] & ~m) | w;
            3'd1: mData[c] = mData[c] | w;
            3'd2: mData[c] = mData[c] & ~w;
            3'd3: mData[c] = mData[c] ^ w;
`ifdef QSYS_GPO_PULSE_EN
            3'd4: begin
                if (mPlen[c] != 16'd0) begin
                    if (cyc <= mPend[c]) mPmask[c] = mPmask[c] | w;
                    else                 mPmask[c] = w;
                    mPend[c] = cyc + int'(mPlen[c]);
                end
            end
            3'd5: begin
                if (b[0]) mPlen[c][7:0]  = d[7:0];
                if (b[1]) mPlen[c][15:8] = d[15:8];
            end
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] a);
        int c;
        c = int'(a[4:3]);
        case (a[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: return mData[c];
`ifdef QSYS_GPO_PULSE_EN
            3'd4: return mData[c];
            3'd5: return {16'h0000, mPlen[c]};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [127:0] expCoe();
        logic [127:0] e;
        for (int c = 0; c < 4; c++) begin
            e[c*32 +: 32] = mData[c] ^ ((cyc < mPend[c]) ? mPmask[c] : 32'h0);
        end
        return e;
    endfunction

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr  = a;
        wd    = d;
        be    = b;
        write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        modelWrite(a, d, b);
    endtask

    task automatic busRead(input logic [4:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        addr = a;
        read = 1'b1;
        #1;
        waits = 0;
        while (waitreq && waits < 8) begin
            @(posedge clk);
            #1;
            waits++;
        end
        d = readdata;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          waits;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (coe !== RST_PATTERN) begin
            errors++;
            $display("[TB] FAIL reset_coe got %h want %h", coe, RST_PATTERN);
        end
        checks++;
        if (waitreq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_wait got %b want 1", waitreq);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (waitreq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_wait got %b want 0", waitreq);
        end
        busRead({2'd2, 3'd0}, d, waits);
        checks++;
        if (d !== 32'h5A5A5A5A) begin
            errors++;
            $display("[TB] FAIL reset_read_ch2 got %h want 5a5a5a5a", d);
        end
        checks++;
        if (waits !== 1) begin
            errors++;
            $display("[TB] FAIL reset_read_waits got %0d want 1", waits);
        end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        int          waits;
        busWrite({2'd1, 3'd0}, 32'h12345678, 4'b0101);
        checks++;
        if (coe !== {32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A345A78, 32'h5A5A5A5A}) begin
            errors++;
            $display("[TB] FAIL byteenable_coe got %h want 5a5a5a5a5a5a5a5a5a345a785a5a5a5a", coe);
        end
        busRead({2'd1, 3'd0}, d, waits);
        checks++;
        if (d !== 32'h5A345A78) begin
            errors++;
            $display("[TB] FAIL byteenable_read got %h want 5a345a78", d);
        end
    endtask

    task automatic test_setclrtog();
        logic [31:0] d;
        int          waits;
        busWrite({2'd0, 3'd1}, 32'h000000F0, 4'hF);
        busWrite({2'd0, 3'd2}, 32'h00000050, 4'hF);
        busWrite({2'd0, 3'd3}, 32'hFF000000, 4'hF);
        checks++;
        if (coe[31:0] !== 32'hA55A5AAA) begin
            errors++;
            $display("[TB] FAIL setclrtog_coe got %h want a55a5aaa", coe[31:0]);
        end
        busRead({2'd0, 3'd3}, d, waits);
        checks++;
        if (d !== 32'hA55A5AAA) begin
            errors++;
            $display("[TB] FAIL setclrtog_read got %h want a55a5aaa", d);
        end
    endtask

    task automatic test_unmapped();
        logic [127:0] snap;
        logic [31:0]  d;
        int           waits;
        snap = coe;
        busWrite({2'd1, 3'd6}, 32'hFFFFFFFF, 4'hF);
        busWrite({2'd2, 3'd7}, 32'hFFFFFFFF, 4'hF);
`ifndef QSYS_GPO_PULSE_EN
        busWrite({2'd3, 3'd4}, 32'hFFFFFFFF, 4'hF);
        busWrite({2'd0, 3'd5}, 32'hFFFFFFFF, 4'hF);
`endif
        checks++;
        if (coe !== snap) begin
            errors++;
            $display("[TB] FAIL unmapped_write got %h want %h", coe, snap);
        end
        busRead({2'd1, 3'd6}, d, waits);
        checks++;
        if (d !== 32'h0 || waits !== 1) begin
            errors++;
            $display("[TB] FAIL unmapped_read got %h/%0d want 0/1", d, waits);
        end
`ifndef QSYS_GPO_PULSE_EN
        busRead({2'd0, 3'd5}, d, waits);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL unmapped_plen_read got %h want 0", d);
        end
`endif
    endtask

    task automatic test_write_read_same();
        @(negedge clk);
        addr  = {2'd2, 3'd0};
        wd    = 32'hCAFEF00D;
        be    = 4'hF;
        write = 1'b1;
        read  = 1'b1;
        #1;
        checks++;
        if (waitreq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_rd_wait got %b want 0", waitreq);
        end
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        modelWrite({2'd2, 3'd0}, 32'hCAFEF00D, 4'hF);
        checks++;
        if (coe[95:64] !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL wr_rd_data got %h want cafef00d", coe[95:64]);
        end
    endtask

`ifdef QSYS_GPO_PULSE_EN
    task automatic test_pulse();
        logic [31:0] d;
        int          waits;
        int          inv;
        busWrite({2'd3, 3'd5}, 32'h00000003, 4'b0011);
        busRead({2'd3, 3'd5}, d, waits);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("[TB] FAIL plen_read got %h want 3", d);
        end
        // single pulse
        busWrite({2'd3, 3'd4}, 32'h00000001, 4'hF);
        inv = (coe[96] !== mData[3][0]) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (coe[96] !== mData[3][0]) inv++;
            checks++;
            if (coe !== expCoe()) begin
                errors++;
                $display("[TB] FAIL pulse_coe cyc %0d got %h want %h", i, coe, expCoe());
            end
        end
        checks++;
        if (inv !== 3) begin
            errors++;
            $display("[TB] FAIL pulse_len got %0d want 3", inv);
        end
        // retrigger two cycles into the pulse
        busWrite({2'd3, 3'd4}, 32'h00000001, 4'hF);
        inv = (coe[96] !== mData[3][0]) ? 1 : 0;
        @(posedge clk);
        #1;
        if (coe[96] !== mData[3][0]) inv++;
        busWrite({2'd3, 3'd4}, 32'h00000001, 4'hF);
        if (coe[96] !== mData[3][0]) inv++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (coe[96] !== mData[3][0]) inv++;
        end
        checks++;
        if (inv !== 5) begin
            errors++;
            $display("[TB] FAIL retrigger_len got %0d want 5", inv);
        end
        // PLEN=0 disables pulses
        busWrite({2'd2, 3'd5}, 32'h00000000, 4'b0011);
        busWrite({2'd2, 3'd4}, 32'h0000FFFF, 4'hF);
        checks++;
        if (coe[95:64] !== mData[2]) begin
            errors++;
            $display("[TB] FAIL plen0_pulse got %h want %h", coe[95:64], mData[2]);
        end
        // DATA write during an active pulse keeps the mask
        busWrite({2'd1, 3'd5}, 32'h00000004, 4'b0011);
        busWrite({2'd1, 3'd4}, 32'h0000000F, 4'hF);
        busWrite({2'd1, 3'd0}, 32'h11110000, 4'hF);
        checks++;
        if (coe[63:32] !== 32'h1111000F) begin
            errors++;
            $display("[TB] FAIL pulse_data_write got %h want 1111000f", coe[63:32]);
        end
    endtask
`endif

    task automatic test_random();
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        logic [3:0]  b;
        int          waits;
        for (int n = 0; n < 60; n++) begin
            a = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 3) == 0) begin
                exp = expRead(a);
                busRead(a, d, waits);
                checks++;
                if (d !== exp || waits !== 1) begin
                    errors++;
                    $display("[TB] FAIL random_read addr %h got %h/%0d want %h/1", a, d, waits, exp);
                end
            end else begin
                d = $urandom;
                b = 4'($urandom_range(0, 15));
                if (a[2:0] == 3'd5) d = 32'($urandom_range(0, 6));
                busWrite(a, d, b);
                checks++;
                if (coe !== expCoe()) begin
                    errors++;
                    $display("[TB] FAIL random_write addr %h got %h want %h", a, coe, expCoe());
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (coe !== expCoe()) begin
                errors++;
                $display("[TB] FAIL random_idle got %h want %h", coe, expCoe());
            end
        end
    endtask

    task automatic test_reset_midread();
        logic [31:0] d;
        int          waits;
        busWrite({2'd1, 3'd0}, 32'h0BADBEEF, 4'hF);
`ifdef QSYS_GPO_PULSE_EN
        busWrite({2'd0, 3'd5}, 32'h0000000A, 4'b0011);
        busWrite({2'd0, 3'd4}, 32'h000000FF, 4'hF);
`endif
        @(negedge clk);
        addr = {2'd1, 3'd0};
        read = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (readdata !== 32'h0BADBEEF) begin
            errors++;
            $display("[TB] FAIL midread_data got %h want 0badbeef", readdata);
        end
        reset = 1'b1;
        #1;
        modelReset();
        checks++;
        if (readdata !== 32'h0 || waitreq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midread_reset got %h/%b want 0/1", readdata, waitreq);
        end
        checks++;
        if (coe !== RST_PATTERN) begin
            errors++;
            $display("[TB] FAIL midread_reset_coe got %h want %h", coe, RST_PATTERN);
        end
        read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        busRead({2'd1, 3'd0}, d, waits);
        checks++;
        if (d !== 32'h5A5A5A5A || waits !== 1) begin
            errors++;
            $display("[TB] FAIL post_reset_read got %h/%0d want 5a5a5a5a/1", d, waits);
        end
        checks++;
        if (coe !== RST_PATTERN) begin
            errors++;
            $display("[TB] FAIL post_reset_coe got %h want %h", coe, RST_PATTERN);
        end
    endtask

    initial begin
        test_reset();
        test_byteenable();
        test_setclrtog();
        test_unmapped();
        test_write_read_same();
`ifdef QSYS_GPO_PULSE_EN
        test_pulse();
`endif
        test_random();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
